stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control and timing for the stopwatch minutes/seconds counter.
//  - Cleans up the raw pause/clear buttons and the adjust/select switches.
//  - Derives the 1 Hz count tick, 2 Hz adjust tick and blink timebase from the master clock.
//  - Runs the RUN/PAUSE/ADJUST state machine.
//  - Outputs single-cycle increment strobes plus a clear strobe; the clk-domain counter consumes them.
// PARAMETERS
//  DIV_1HZ    100_000_000  clk cycles per run-mode seconds tick
//  DIV_2HZ     50_000_000  clk cycles per adjust-mode tick
//  DIV_BLINK   25_000_000  clk cycles per blink_on toggle
//  DB_CYCLES    1_000_000  consecutive stable cycles needed to accept an input change
// PORTS
//  clk        in   1  master clock
//  reset      in   1  synchronous, active-high reset
//  btn_pause  in   1  raw pause button, asynchronous, bouncy
//  btn_clr    in   1  raw clear button, asynchronous, bouncy
//  sw_adj     in   1  raw adjust switch: 1 = adjust mode
//  sw_sel     in   1  raw select switch: 1 = minutes, 0 = seconds
//  tick_sec   out  1  1-cycle pulse: increment seconds
//  tick_min   out  1  1-cycle pulse: increment minutes
//  count_clr  out  1  1-cycle pulse: zero minutes and seconds
//  adj_mode   out  1  level: counter suppresses seconds->minutes carry
//  blink_on   out  1  level: display blink phase for the selected field
//  paused     out  1  level: remembered pause flag
// BEHAVIOUR
//  Reset values
//   - state=RUN; all dividers=0; synchronisers and debounced levels=0.
//   - tick_sec=tick_min=count_clr=0; adj_mode=0; paused=0; blink_on=1.
//  Input conditioning
//   - Each input: 2-flop synchroniser, then stability counter. Debounced level updates only
//     after DB_CYCLES consecutive equal samples; any mismatch restarts the count.
//   - Buttons: rising edge of the debounced level gives a 1-cycle press.
//     Latency from a clean input step to the press pulse is DB_CYCLES+3 cycles.
//  State machine (states RUN, PAUSE, ADJ)
//   - RUN  -- pause press  --> PAUSE, paused=1
//   - PAUSE -- pause press --> RUN, paused=0
//   - Any state -- debounced sw_adj=1 --> ADJ. sw_adj has priority over a same-cycle pause press.
//   - ADJ -- sw_adj=0 --> PAUSE if paused=1, else RUN.
//   - In ADJ a pause press toggles paused only; the state is unchanged.
//   - adj_mode = (state==ADJ), registered.
//  Tick generation
//   - div1: counts 0..DIV_1HZ-1 in RUN only. tick_sec=1 in the cycle it wraps, i.e. first tick
//     DIV_1HZ cycles after it was last zeroed.
//   - div1 is zeroed on reset, on clear press, and on every entry to RUN.
//   - div2: counts in ADJ only; zeroed on ADJ entry. On wrap it pulses tick_min if sel=1,
//     else tick_sec.
//   - tick_min is never asserted outside ADJ; in RUN the minutes carry belongs to the counter.
//   - blink: free-running divider; blink_on toggles every DIV_BLINK cycles.
//  Clear
//   - A clear press gives count_clr=1 for exactly one cycle in any state; the state is unchanged.
//   - Same cycle as a tick wrap: clear wins and both tick strobes are 0 that cycle.
//   - Same cycle as a pause press: both take effect.
//  Mutual exclusion
//   - At most one of tick_sec/tick_min/count_clr is high in any cycle.
//  Reset mid-operation
//   - All registers return to reset values at the next edge, including partial debounce counts.
// STRUCTURE
//  - stopwatch_pkg holds the state encoding (ST_RUN=2'd0, ST_PAUSE=2'd1, ST_ADJ=2'd2) and the
//    default divider constants.
//  - Sub-module btn_debounce (synchroniser, stability counter, level + rise outputs),
//    instantiated 4x, one per raw input.
// TESTING  (DIV_1HZ=10, DIV_2HZ=5, DIV_BLINK=4, DB_CYCLES=4)
//  1. Release reset, idle 35 cycles -> tick_sec at cycles 10/20/30; tick_min=0; paused=0;
//     blink_on toggles every 4 cycles.
//  2. btn_pause bounces 1,0,1 then holds high 8 cycles -> one press, PAUSE, tick_sec stops.
//     A second press -> RUN; next tick_sec 10 cycles after RUN entry.
//  3. Clear press aligned to a div1 wrap -> count_clr=1 for 1 cycle, no tick_sec that cycle;
//     next tick_sec 10 cycles later; state stays RUN.
//  4. From PAUSE set sw_adj=1, sw_sel=1 -> adj_mode=1 and tick_min every 5 cycles, tick_sec=0.
//     sw_sel=0 -> tick_sec every 5 cycles. sw_adj=0 -> PAUSE, adj_mode=0.
//  5. In ADJ with paused=0, a pause press -> paused=1, state stays ADJ.
//     sw_adj=0 -> PAUSE, no ticks.
//  6. Assert reset mid-ADJ with a debounce in progress -> next edge: all reset values;
//     the pending press is never emitted.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: state encoding, default
// divider constants and a counter-width helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_e;

  localparam int unsigned DEF_DIV_1HZ   = 100_000_000;
  localparam int unsigned DEF_DIV_2HZ   = 50_000_000;
  localparam int unsigned DEF_DIV_BLINK = 25_000_000;
  localparam int unsigned DEF_DB_CYCLES = 1_000_000;

  // Bits needed for a counter spanning 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw input; provides the
// debounced level and a registered one-cycle pulse on its rising edge.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_dly_q, rise_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= din;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions the raw buttons/switches, runs the RUN/PAUSE/ADJ
// machine and issues single-cycle increment and clear strobes to the counter.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV_1HZ   = DEF_DIV_1HZ,
  parameter int unsigned DIV_2HZ   = DEF_DIV_2HZ,
  parameter int unsigned DIV_BLINK = DEF_DIV_BLINK,
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_pause,
  input  logic btn_clr,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic tick_sec,
  output logic tick_min,
  output logic count_clr,
  output logic adj_mode,
  output logic blink_on,
  output logic paused
);

  localparam int unsigned D1W = cnt_width(DIV_1HZ);
  localparam int unsigned D2W = cnt_width(DIV_2HZ);
  localparam int unsigned DBW = cnt_width(DIV_BLINK);
  localparam logic [D1W-1:0] Div1Max  = D1W'(DIV_1HZ - 1);
  localparam logic [D2W-1:0] Div2Max  = D2W'(DIV_2HZ - 1);
  localparam logic [DBW-1:0] BlinkMax = DBW'(DIV_BLINK - 1);

  logic pause_press, clr_press, adj_lvl, sel_lvl;
  logic pause_level_unused, clr_level_unused, adj_rise_unused, sel_rise_unused;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
    .clk  (clk),
    .reset(reset),
    .din  (btn_pause),
    .level(pause_level_unused),
    .rise (pause_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk  (clk),
    .reset(reset),
    .din  (btn_clr),
    .level(clr_level_unused),
    .rise (clr_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adj (
    .clk  (clk),
    .reset(reset),
    .din  (sw_adj),
    .level(adj_lvl),
    .rise (adj_rise_unused)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (
    .clk  (clk),
    .reset(reset),
    .din  (sw_sel),
    .level(sel_lvl),
    .rise (sel_rise_unused)
  );

  state_e state_q, state_d;
  logic   paused_q, paused_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paused_d = paused_q;
    unique case (state_q)
      ST_RUN: begin
        if (pause_press) begin
          state_d  = ST_PAUSE;
          paused_d = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (pause_press) begin
          state_d  = ST_RUN;
          paused_d = 1'b0;
        end
      end
      ST_ADJ: begin
        if (pause_press) paused_d = ~paused_q;
        if (!adj_lvl) state_d = paused_d ? ST_PAUSE : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    // Entering adjust swallows a same-cycle pause press.
    if (adj_lvl && (state_q != ST_ADJ)) begin
      state_d  = ST_ADJ;
      paused_d = paused_q;
    end
  end

  logic [D1W-1:0] div1_q, div1_d;
  logic [D2W-1:0] div2_q, div2_d;
  logic [DBW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_q, blink_d;
  logic           wrap1, wrap2;
  logic           tick_sec_q, tick_sec_d, tick_min_q, tick_min_d;
  logic           count_clr_q, adj_mode_q;

  always_comb begin
    div1_d     = div1_q;
    div2_d     = div2_q;
    tick_sec_d = 1'b0;
    tick_min_d = 1'b0;
    wrap1      = (state_q == ST_RUN) && (div1_q == Div1Max);
    wrap2      = (state_q == ST_ADJ) && (div2_q == Div2Max);
    if (state_q == ST_RUN) div1_d = wrap1 ? '0 : div1_q + 1'b1;
    if (state_q == ST_ADJ) div2_d = wrap2 ? '0 : div2_q + 1'b1;
    if (clr_press || ((state_q != ST_RUN) && (state_d == ST_RUN))) div1_d = '0;
    if ((state_q != ST_ADJ) && (state_d == ST_ADJ)) div2_d = '0;
    // Clear outranks any tick landing in the same cycle.
    if (!clr_press) begin
      tick_sec_d = wrap1 || (wrap2 && !sel_lvl);
      tick_min_d = wrap2 && sel_lvl;
    end
    blink_cnt_d = (blink_cnt_q == BlinkMax) ? '0 : blink_cnt_q + 1'b1;
    blink_d     = (blink_cnt_q == BlinkMax) ? ~blink_q : blink_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div1_q      <= '0;
      div2_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      tick_sec_q  <= 1'b0;
      tick_min_q  <= 1'b0;
      count_clr_q <= 1'b0;
      adj_mode_q  <= 1'b0;
    end else begin
      div1_q      <= div1_d;
      div2_q      <= div2_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      tick_sec_q  <= tick_sec_d;
      tick_min_q  <= tick_min_d;
      count_clr_q <= clr_press;
      adj_mode_q  <= (state_d == ST_ADJ);
    end
  end

  assign tick_sec  = tick_sec_q;
  assign tick_min  = tick_min_q;
  assign count_clr = count_clr_q;
  assign adj_mode  = adj_mode_q;
  assign blink_on  = blink_q;
  assign paused    = paused_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small dividers: exact-cycle idle run,
// a segment table of held inputs with expected strobe counts, and a reset case.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_pause = 1'b0, btn_clr = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic tick_sec, tick_min, count_clr, adj_mode, blink_on, paused;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_sec, n_min, n_clr;

  typedef struct {
    logic p, c, a, s;
    int   n;
    int   e_sec, e_min, e_clr;
    logic e_adj, e_pau;
  } seg_t;

  seg_t segs[$];

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .DIV_1HZ  (10),
    .DIV_2HZ  (5),
    .DIV_BLINK(4),
    .DB_CYCLES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_pause(btn_pause),
    .btn_clr  (btn_clr),
    .sw_adj   (sw_adj),
    .sw_sel   (sw_sel),
    .tick_sec (tick_sec),
    .tick_min (tick_min),
    .count_clr(count_clr),
    .adj_mode (adj_mode),
    .blink_on (blink_on),
    .paused   (paused)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; accumulates strobe counts.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    n_sec += int'(tick_sec);
    n_min += int'(tick_min);
    n_clr += int'(count_clr);
    check("strobe_exclusive", int'(tick_sec) + int'(tick_min) + int'(count_clr) > 1 ? 1 : 0, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " tick_sec"}, int'(tick_sec), 0);
    check({tag, " tick_min"}, int'(tick_min), 0);
    check({tag, " count_clr"}, int'(count_clr), 0);
    check({tag, " adj_mode"}, int'(adj_mode), 0);
    check({tag, " blink_on"}, int'(blink_on), 1);
    check({tag, " paused"}, int'(paused), 0);
  endtask

  task automatic add(input logic p, input logic c, input logic a, input logic s, input int n,
                     input int es, input int em, input int ec, input logic ea, input logic ep);
    seg_t r;
    r.p = p; r.c = c; r.a = a; r.s = s; r.n = n;
    r.e_sec = es; r.e_min = em; r.e_clr = ec; r.e_adj = ea; r.e_pau = ep;
    segs.push_back(r);
  endtask

  initial begin
    // Cycle numbers count edges after the last reset edge (cycle 0).
    // Pause press: bounce 1,0,1 then 8 high; press acts at 45, tick at 40.
    add(1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,  8, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 20, 0, 0, 0, 0, 1);
    // Second press re-enters RUN at 73; next tick exactly at 83.
    add(1, 0, 0, 0,  6, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,  2, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  9, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    // Clear lands on the wrap at 103; tick suppressed, next tick at 113.
    add(0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0,  7, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0,  9, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    // Pause at 121, then adjust minutes from 130 (ticks 135, 140, 145).
    add(1, 0, 0, 0,  6, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,  4, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1,  7, 0, 0, 0, 1, 1);
    add(0, 0, 1, 1,  4, 0, 0, 0, 1, 1);
    add(0, 0, 1, 1,  1, 0, 1, 0, 1, 1);
    add(0, 0, 1, 1,  5, 0, 1, 0, 1, 1);
    // Select seconds: level changes at 146, so 145 is still a minute tick.
    add(0, 0, 1, 0,  5, 0, 1, 0, 1, 1);
    add(0, 0, 1, 0,  5, 1, 0, 0, 1, 1);
    add(0, 0, 1, 0,  5, 1, 0, 0, 1, 1);
    // Leave adjust at 162 back to PAUSE.
    add(0, 0, 0, 0,  7, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 10, 0, 0, 0, 0, 1);
    // RUN at 180, ADJ at 187, pause press toggles paused at 195, exit to PAUSE at 203.
    add(1, 0, 0, 0,  6, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,  2, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1,  7, 0, 0, 0, 1, 0);
    add(1, 0, 1, 1,  6, 0, 1, 0, 1, 0);
    add(0, 0, 1, 1,  3, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1,  7, 0, 2, 0, 0, 1);
    add(0, 0, 0, 1, 10, 0, 0, 0, 0, 1);
    // Back into adjust (ADJ at 220) ahead of the reset case.
    add(0, 0, 1, 0,  7, 0, 0, 0, 1, 1);

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_reset_vals("reset");
    reset = 1'b0;
    cyc = 0;
    n_sec = 0; n_min = 0; n_clr = 0;

    // Idle run: ticks every 10 cycles, blink toggles every 4.
    for (int i = 0; i < 35; i++) begin
      step();
      check("idle tick_sec", int'(tick_sec), (cyc % 10 == 0) ? 1 : 0);
      check("idle blink_on", int'(blink_on), ((cyc / 4) % 2 == 0) ? 1 : 0);
      check("idle tick_min", int'(tick_min), 0);
      check("idle paused", int'(paused), 0);
    end

    for (int i = 0; i < segs.size(); i++) begin
      btn_pause = segs[i].p;
      btn_clr   = segs[i].c;
      sw_adj    = segs[i].a;
      sw_sel    = segs[i].s;
      n_sec = 0; n_min = 0; n_clr = 0;
      repeat (segs[i].n) step();
      check($sformatf("seg%0d tick_sec count", i), n_sec, segs[i].e_sec);
      check($sformatf("seg%0d tick_min count", i), n_min, segs[i].e_min);
      check($sformatf("seg%0d count_clr count", i), n_clr, segs[i].e_clr);
      check($sformatf("seg%0d adj_mode", i), int'(adj_mode), int'(segs[i].e_adj));
      check($sformatf("seg%0d paused", i), int'(paused), int'(segs[i].e_pau));
    end

    // Reset in adjust with a pause press half-debounced.
    btn_pause = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    btn_pause = 1'b0;
    sw_adj = 1'b0;
    sw_sel = 1'b0;
    step();
    check_reset_vals("midreset");
    reset = 1'b0;
    cyc = 0;
    n_sec = 0; n_min = 0; n_clr = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("post-reset paused", int'(paused), 0);
      check("post-reset adj_mode", int'(adj_mode), 0);
      check("post-reset tick_sec", int'(tick_sec), (cyc == 10) ? 1 : 0);
    end
    check("post-reset tick_min count", n_min, 0);
    check("post-reset count_clr count", n_clr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
